// File: rtl/audio_pkg.sv
// Shared defaults and FSM state encoding for the I2S DAC transmitter.
package audio_pkg;
  localparam int unsigned DATA_W_DEF = 24;
  localparam int unsigned SLOT_W_DEF = 32;

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_e;
endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser followed by a delay flop for rise/fall detection.
module edge_sync (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);
  logic s1_q, s2_q, s3_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;
endmodule

// File: rtl/audio_dac_tx.sv
// I2S transmitter slaved to codec BCLK/LRCK, with a one-entry stereo holding register.
module audio_dac_tx
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SLOT_W = SLOT_W_DEF
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              AUD_BCLK,
  input  logic              AUD_DACLRCK,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              AUD_DACDAT,
  output logic              underrun
);
  localparam int unsigned CNT_W = $clog2(SLOT_W + 1);
  localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic bclk_fall, bclk_rise_unused, lrck_rise, lrck_fall;

  edge_sync u_bclk_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .async_in (AUD_BCLK),
    .rise     (bclk_rise_unused),
    .fall     (bclk_fall)
  );

  edge_sync u_lrck_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .async_in (AUD_DACLRCK),
    .rise     (lrck_rise),
    .fall     (lrck_fall)
  );

  state_e            state_q;
  logic              hold_full_q;
  logic [DATA_W-1:0] hold_l_q, hold_r_q;
  logic [DATA_W-1:0] act_l_q, act_r_q;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ld_q, ld_right_q;
  logic              dac_q, under_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      act_l_q     <= '0;
      act_r_q     <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      ld_q        <= 1'b0;
      ld_right_q  <= 1'b0;
      dac_q       <= 1'b0;
      under_q     <= 1'b0;
    end else begin
      under_q <= 1'b0;
      ld_q    <= 1'b0;
      // Shift register loads from the active pair one cycle after the LRCK edge;
      // BCLK is slow enough that no shift can fall in that gap.
      if (ld_q) begin
        shift_q <= ld_right_q ? act_r_q : act_l_q;
      end
      if (in_valid && !hold_full_q) begin
        hold_l_q    <= in_left;
        hold_r_q    <= in_right;
        hold_full_q <= 1'b1;
      end
      if (lrck_fall) begin
        state_q    <= LEFT;
        cnt_q      <= '0;
        ld_q       <= 1'b1;
        ld_right_q <= 1'b0;
        if (hold_full_q) begin
          act_l_q     <= hold_l_q;
          act_r_q     <= hold_r_q;
          hold_full_q <= 1'b0;
        end else begin
          act_l_q <= '0;
          act_r_q <= '0;
          under_q <= 1'b1;
        end
      end else if (lrck_rise) begin
        cnt_q <= '0;
        if (state_q == LEFT) begin
          state_q    <= RIGHT;
          ld_q       <= 1'b1;
          ld_right_q <= 1'b1;
        end
      end else if (bclk_fall && state_q != IDLE) begin
        if (cnt_q < DATA_CNT) begin
          dac_q   <= shift_q[DATA_W-1];
          shift_q <= {shift_q[DATA_W-2:0], 1'b0};
        end else begin
          dac_q <= 1'b0;
        end
        if (cnt_q != SLOT_CNT) begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end
    end
  end

  assign in_ready   = ~hold_full_q;
  assign AUD_DACDAT = dac_q;
  assign underrun   = under_q;
endmodule

// File: tb/tb_audio_dac_tx.sv
// Bench for audio_dac_tx: codec-master BCLK/LRCK model with a bit-level scoreboard.
module tb_audio_dac_tx;
  localparam int unsigned DW = 24;
  localparam int unsigned SW = 32;
  localparam int HB = 163;

  logic clk = 1'b0;
  logic rst, bclk, lrck, in_valid, in_ready, dacdat, underrun;
  logic [DW-1:0] in_left, in_right;

  always #10 clk = ~clk;

  audio_dac_tx #(.DATA_W(DW), .SLOT_W(SW)) dut (
    .CLOCK_50    (clk),
    .reset       (rst),
    .AUD_BCLK    (bclk),
    .AUD_DACLRCK (lrck),
    .in_left     (in_left),
    .in_right    (in_right),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .AUD_DACDAT  (dacdat),
    .underrun    (underrun)
  );

  typedef struct packed { logic [DW-1:0] l; logic [DW-1:0] r; } pair_t;
  typedef struct { bit offer; logic [DW-1:0] l; logic [DW-1:0] r; int nl; int nr; int und; } vec_t;

  int    total = 0, bad = 0;
  pair_t pair_q[$];
  logic  exp_q[$];
  pair_t cur;
  logic  last_bit;
  bit    dut_idle;
  int    exp_under = 0, under_cnt = 0;
  bit    stop;
  int    acc_n;

  always @(negedge clk) if (underrun === 1'b1) under_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    bit done = 0;
    pair_t p;
    p.l = l;
    p.r = r;
    @(posedge clk); #2;
    in_valid = 1'b1; in_left = l; in_right = r;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        pair_q.push_back(p);
        done = 1;
      end
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL send_pair: in_ready low for 2000 cycles, required high");
    end
  endtask

  // One LRCK half-frame of n BCLKs; LRCK changes on the first BCLK fall.
  task automatic half_frame(input bit right, input int n, input int rst_at);
    logic [DW-1:0] s;
    logic b;
    if (!right) begin
      dut_idle = 0;
      if (pair_q.size() > 0) cur = pair_q.pop_front();
      else begin
        cur = '0;
        exp_under++;
      end
      s = cur.l;
    end else begin
      s = dut_idle ? '0 : cur.r;
    end
    exp_q.push_back(last_bit);
    for (int k = 1; k < n; k++) begin
      b = (k <= int'(DW)) ? s[int'(DW) - k] : 1'b0;
      exp_q.push_back(b);
    end
    last_bit = exp_q[$];
    for (int k = 0; k < n; k++) begin
      #HB bclk = 1'b0;
      if (k == 0) lrck = right;
      #HB bclk = 1'b1;
      #1;
      b = exp_q.pop_front();
      check($sformatf("dacdat %s bit %0d", right ? "R" : "L", k), dacdat, b);
      if (k == rst_at) begin
        @(negedge clk);
        if (pair_q.size() > 0) check("in_ready before reset", in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("dacdat after reset", dacdat, 0);
        check("in_ready after reset", in_ready, 1);
        check("underrun after reset", underrun, 0);
        rst = 1'b0;
        pair_q.delete();
        exp_q.delete();
        for (int j = k + 1; j < n; j++) exp_q.push_back(1'b0);
        dut_idle = 1;
        last_bit = 1'b0;
      end
    end
  endtask

  initial begin
    vec_t vecs[4];
    int u0;
    logic [DW-1:0] v;

    vecs[0] = '{1'b1, 24'hA5A5A5, 24'h5A5A5A, 32, 32, 0};
    vecs[1] = '{1'b0, 24'h000000, 24'h000000, 32, 32, 1};
    vecs[2] = '{1'b0, 24'h000000, 24'h000000, 32, 32, 1};
    vecs[3] = '{1'b1, 24'h800000, 24'h123456, 20, 32, 0};

    rst = 1'b1; bclk = 1'b1; lrck = 1'b1;
    in_valid = 1'b0; in_left = '0; in_right = '0;
    last_bit = 1'b0; dut_idle = 1;
    repeat (4) @(posedge clk);
    #1;
    check("reset dacdat", dacdat, 0);
    check("reset in_ready", in_ready, 1);
    check("reset underrun", underrun, 0);
    @(negedge clk) rst = 1'b0;

    half_frame(1, 32, -1);

    for (int i = 0; i < 4; i++) begin
      u0 = under_cnt;
      if (vecs[i].offer) send_pair(vecs[i].l, vecs[i].r);
      half_frame(0, vecs[i].nl, -1);
      half_frame(1, vecs[i].nr, -1);
      check($sformatf("vec%0d underrun pulses", i), under_cnt - u0, vecs[i].und);
    end

    u0 = under_cnt;
    stop = 0; acc_n = 0;
    fork
      begin
        v = 24'h6B4001;
        @(posedge clk); #2;
        in_valid = 1'b1; in_left = v; in_right = v;
        while (!stop) begin
          @(negedge clk);
          if (!stop && in_ready) begin
            pair_q.push_back({v, v});
            acc_n++;
            @(posedge clk); #2;
            v = v + 1'b1;
            in_left = v; in_right = v;
          end
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        for (int f = 0; f < 4; f++) begin
          half_frame(0, 32, -1);
          half_frame(1, 32, -1);
        end
        stop = 1;
      end
    join
    check("stream pairs accepted", acc_n, 5);
    check("stream underrun pulses", under_cnt - u0, 0);

    u0 = under_cnt;
    fork
      half_frame(0, 32, 10);
      begin
        repeat (3) @(posedge bclk);
        send_pair(24'h13579B, 24'h2468AC);
      end
    join
    half_frame(1, 32, -1);
    send_pair(24'hC0FFEE, 24'h0BEEF1);
    half_frame(0, 32, -1);
    half_frame(1, 32, -1);
    check("post-reset underrun pulses", under_cnt - u0, 0);
    check("total underrun pulses", under_cnt, exp_under);
    check("scoreboard drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/audio_dac_tx.md
AUDIO_DAC_TX -- requirements
Module: audio_dac_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning the sample width in bits per channel.
REQ-002 SHALL have parameter SLOT_W, default 32, meaning the BCLK periods per LRCK half-frame.
REQ-003 SHALL have port CLOCK_50  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous reset, active-high.
REQ-005 SHALL have port AUD_BCLK  in  1  codec bit clock (codec is master), asynchronous to CLOCK_50, at most CLOCK_50/8.
REQ-006 SHALL have port AUD_DACLRCK  in  1  codec DAC word clock; low = left half, high = right half.
REQ-007 SHALL have port in_left  in  DATA_W  left sample, two's complement.
REQ-008 SHALL have port in_right  in  DATA_W  right sample, two's complement.
REQ-009 SHALL have port in_valid  in  1  stereo pair offered.
REQ-010 SHALL have port in_ready  out  1  holding register empty; pair accepted when in_valid && in_ready.
REQ-011 SHALL have port AUD_DACDAT  out  1  I2S serial data to codec.
REQ-012 SHALL have port underrun  out  1  one-cycle pulse when a left frame starts with no pair held.

Function
REQ-013 SHALL synchronise AUD_BCLK and AUD_DACLRCK through 2 flops each, then detect edges from the synchronised signal and its 1-cycle delay.
REQ-014 SHALL keep a one-entry holding register {left,right}; in_ready = holding empty; an accepted pair SHALL set holding full on the next edge.
REQ-015 SHALL use states IDLE, LEFT, RIGHT; IDLE->LEFT on LRCK falling edge, LEFT->RIGHT on LRCK rising edge, RIGHT->LEFT on LRCK falling edge.
REQ-016 SHALL ignore all BCLK and data activity in IDLE, driving AUD_DACDAT = 0.
REQ-017 SHALL, on each LRCK falling edge, move the holding pair into the active pair register, clear holding, and load the left sample into the shift register; if holding is empty it SHALL load zeros for both channels and pulse underrun.
REQ-018 SHALL, on each LRCK rising edge in LEFT, load the active right sample into the shift register.
REQ-019 SHALL reset the bit counter to 0 on every LRCK edge; a BCLK falling edge detected in the same cycle as the LRCK edge SHALL NOT shift.
REQ-020 SHALL drive the MSB on the first BCLK falling edge after the LRCK edge (I2S one-bit delay), and shift one bit per subsequent BCLK falling edge, MSB first.
REQ-021 SHALL drive bits DATA_W..SLOT_W-1 of each half-frame as 0; the counter SHALL saturate at SLOT_W, and extra BCLKs SHALL output 0.
REQ-022 SHALL, on a short half-frame (LRCK edge before SLOT_W bits), abandon the remaining bits and start the new half-frame normally; this SHALL NOT set underrun.
REQ-023 SHALL change AUD_DACDAT only in the cycle after a detected BCLK falling edge, or on reset/IDLE entry.
REQ-024 SHALL give priority to the frame-start load over an input accept in the same cycle; in_ready SHALL rise the cycle after holding clears.
REQ-025 SHALL not modify holding while it is full, regardless of in_valid.

Reset
REQ-026 SHALL, on reset, set state IDLE, AUD_DACDAT 0, in_ready 1, underrun 0, holding empty, active pair 0, counter 0, and synchroniser flops 0.
REQ-027 SHALL, on reset mid-frame, discard holding and active pair and resume output only from the next LRCK falling edge.

Structure
REQ-028 SHALL take DATA_W/SLOT_W defaults and the state enum {IDLE, LEFT, RIGHT} from shared package audio_pkg.
REQ-029 SHALL implement sync+edge detect as sub-module edge_sync (ports CLOCK_50, reset, async_in, rise, fall), instantiated for BCLK and LRCK.

Verification
REQ-030 SHALL verify: pair L=24'hA5A5A5, R=24'h5A5A5A before a frame, BCLK=3.072 MHz, LRCK=48 kHz -> DACDAT shows A5A5A5 in bits 1..24 after LRCK fall, 5A5A5A after LRCK rise, 8 zeros each half.
REQ-031 SHALL verify: no pair offered across a frame -> underrun pulses once per LRCK fall, 64 zero bits output.
REQ-032 SHALL verify: in_valid held high with incrementing L=R=n -> one pair consumed per 48 kHz frame, in_ready high for one-plus cycles after each LRCK fall, no pair dropped or repeated.
REQ-033 SHALL verify: L=24'h800000 with LRCK half-frame of 20 BCLKs -> first 19 bits transmitted, then right half starts cleanly; no underrun.
REQ-034 SHALL verify: reset asserted at bit 10 of the left half -> DACDAT=0 and in_ready=1 next cycle; output stays 0 until the next LRCK fall, then starts a correct frame.
